// File: rtl/mkio_manchester_rx.sv
// rtl/mkio_manchester_rx.sv - MIL-STD-1553B Manchester word receiver for one MKIO channel
// Open-loop sampler timed from the mid-sync transition; no mid-bit resync.
module mkio_manchester_rx #(
   parameter int CLK_PER_HALF = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        di1,
   input  logic        di0,
   input  logic        rx_strob,
   output logic [15:0] word_data,
   output logic        word_cmd,
   output logic        parity_err,
   output logic        word_valid,
   output logic        rx_err,
   output logic        busy
);

   localparam int H       = CLK_PER_HALF;
   localparam int CW      = $clog2(2 * H);
   localparam int RUN_MIN = 3 * H - 4;

   localparam logic [CW-1:0] LOAD_SYNC2 = CW'(3 * H / 2 - 1);
   localparam logic [CW-1:0] LOAD_FIRST = CW'(2 * H - 1);
   localparam logic [CW-1:0] LOAD_HALF  = CW'(H - 1);

   localparam logic [1:0] LVL_HI = 2'b10;
   localparam logic [1:0] LVL_LO = 2'b01;

   typedef enum logic [1:0] {HUNT, SYNC2, DATA} state_t;

   logic [1:0]    sync1_q, sync2_q;
   logic [1:0]    prev_lvl_q;
   logic [7:0]    run_q, run_d;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          half_q;
   logic [4:0]    bit_q;
   logic [1:0]    first_q;
   logic [1:0]    t0_lvl_q;
   logic          cmd_q;
   logic [15:0]   data_q;
   logic [15:0]   word_data_q;
   logic          word_cmd_q, parity_err_q, word_valid_q, rx_err_q, busy_q;

   logic [1:0] lvl;
   logic       lvl_valid, mid_sync, bit_ok, bit_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {di1, di0};
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      lvl       = sync2_q;
      lvl_valid = (lvl == LVL_HI) || (lvl == LVL_LO);
      run_d     = run_q;
      if (!lvl_valid)
         run_d = 8'd0;
      else if (lvl != prev_lvl_q)
         run_d = 8'd1;
      else if (run_q != 8'hFF)
         run_d = run_q + 8'd1;
      // run_q still holds the length of the previous level in the first cycle of the new one
      mid_sync = lvl_valid && (lvl != prev_lvl_q) && (int'(run_q) >= RUN_MIN);
      bit_ok   = ((first_q == LVL_HI) && (lvl == LVL_LO)) ||
                 ((first_q == LVL_LO) && (lvl == LVL_HI));
      bit_val  = (first_q == LVL_HI);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_lvl_q <= 2'b00;
         run_q      <= 8'd0;
      end else begin
         prev_lvl_q <= lvl;
         run_q      <= run_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= HUNT;
         cnt_q        <= '0;
         half_q       <= 1'b0;
         bit_q        <= 5'd0;
         first_q      <= 2'b00;
         t0_lvl_q     <= 2'b00;
         cmd_q        <= 1'b0;
         data_q       <= 16'h0000;
         word_data_q  <= 16'h0000;
         word_cmd_q   <= 1'b0;
         parity_err_q <= 1'b0;
         word_valid_q <= 1'b0;
         rx_err_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         word_valid_q <= 1'b0;
         rx_err_q     <= 1'b0;
         if (!rx_strob) begin
            state_q <= HUNT;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               HUNT: begin
                  if (mid_sync) begin
                     state_q  <= SYNC2;
                     busy_q   <= 1'b1;
                     cmd_q    <= (prev_lvl_q == LVL_HI);
                     t0_lvl_q <= lvl;
                     cnt_q    <= LOAD_SYNC2;
                  end
               end
               SYNC2: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - CW'(1);
                  end else if (lvl == t0_lvl_q) begin
                     state_q <= DATA;
                     cnt_q   <= LOAD_FIRST;
                     half_q  <= 1'b0;
                     bit_q   <= 5'd0;
                  end else begin
                     rx_err_q <= 1'b1;
                     state_q  <= HUNT;
                     busy_q   <= 1'b0;
                  end
               end
               DATA: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - CW'(1);
                  end else if (!half_q) begin
                     if (!lvl_valid) begin
                        rx_err_q <= 1'b1;
                        state_q  <= HUNT;
                        busy_q   <= 1'b0;
                     end else begin
                        first_q <= lvl;
                        half_q  <= 1'b1;
                        cnt_q   <= LOAD_HALF;
                     end
                  end else if (!bit_ok) begin
                     rx_err_q <= 1'b1;
                     state_q  <= HUNT;
                     busy_q   <= 1'b0;
                  end else if (bit_q == 5'd16) begin
                     word_data_q  <= data_q;
                     word_cmd_q   <= cmd_q;
                     parity_err_q <= ~(^data_q ^ bit_val);
                     word_valid_q <= 1'b1;
                     state_q      <= HUNT;
                     busy_q       <= 1'b0;
                  end else begin
                     data_q <= {data_q[14:0], bit_val};
                     bit_q  <= bit_q + 5'd1;
                     half_q <= 1'b0;
                     cnt_q  <= LOAD_HALF;
                  end
               end
               default: begin
                  state_q <= HUNT;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign word_data  = word_data_q;
   assign word_cmd   = word_cmd_q;
   assign parity_err = parity_err_q;
   assign word_valid = word_valid_q;
   assign rx_err     = rx_err_q;
   assign busy       = busy_q;

endmodule
